// File: rtl/pdu_rb_reader.sv
// Consumer side of the PDU ring buffer: reads descriptor + payload flits from the ring RAM
// and streams each accepted PDU payload out as an Avalon-ST packet.
module pdu_rb_reader #(
  parameter int unsigned PDU_AWIDTH    = 12,
  parameter int unsigned RD_LAT        = 2,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned AF_MARGIN     = 64,
  parameter int unsigned MAX_PDU_BYTES = 9216
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  rb_update_valid,
  input  logic [PDU_AWIDTH-1:0] rb_update_size,
  output logic                  rb_rd_en,
  output logic [PDU_AWIDTH-1:0] rb_rd_addr,
  input  logic [511:0]          rb_rd_data,
  output logic [PDU_AWIDTH-1:0] rb_rd_base_addr,
  output logic                  rb_almost_full,
  input  logic                  enable,
  output logic [511:0]          out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [5:0]            out_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           pdu_cnt,
  output logic [31:0]           drop_cnt,
  output logic                  ovf_err
);

  localparam int unsigned RB_DEPTH = 2 ** PDU_AWIDTH;
  localparam int unsigned UW       = PDU_AWIDTH + 1;
  localparam int unsigned SW       = PDU_AWIDTH + 2;
  localparam int unsigned FA_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FC_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned REM_W    = 27;
  localparam int unsigned TAG_W    = 10;  // {hdr, keep, sop, eop, empty[5:0]}
  localparam int unsigned ENT_W    = 520; // {sop, eop, empty[5:0], data[511:0]}

  typedef enum logic [1:0] {IDLE, HDR_RD, PAYLOAD, DROP} state_t;

  state_t             state, state_nxt;
  logic [UW-1:0]      used;
  logic [REM_W-1:0]   rem;
  logic               first;
  logic [5:0]         last_empty;
  logic [FC_W-1:0]    inflight;
  logic [FC_W-1:0]    fifo_cnt;
  logic [FA_W-1:0]    wr_idx, rd_idx;
  logic [RD_LAT:0]    pv;
  logic [TAG_W-1:0]   pt [RD_LAT+1];
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic               can_issue_c, issue_c, load_hdr_c, drop_inc_c, last_c, hdr_ret_c;
  logic               push_c, load_out_c;
  logic [TAG_W-1:0]   tag_c;
  logic [31:0]        hdr_bytes_c;
  logic [REM_W-1:0]   hdr_rem_c;
  logic [5:0]         hdr_empty_c;
  logic [SW-1:0]      sum_c, sat_c;
  logic [UW-1:0]      used_nxt_c;

  // Credit check counts in-flight reads so the skid FIFO can never overflow
  assign can_issue_c = enable && (used != '0) &&
                       ((32'(fifo_cnt) + 32'(inflight)) < FIFO_DEPTH);
  assign hdr_ret_c   = pv[RD_LAT] && pt[RD_LAT][9];
  assign push_c      = pv[RD_LAT] && pt[RD_LAT][8];
  assign load_out_c  = (fifo_cnt != '0) && (!out_valid || out_ready);
  assign last_c      = (rem == REM_W'(1));
  assign hdr_bytes_c = rb_rd_data[31:0];
  assign hdr_rem_c   = REM_W'((33'(hdr_bytes_c) + 33'd63) >> 6);
  assign hdr_empty_c = (hdr_bytes_c[5:0] == 6'd0) ? 6'd0 : 6'(7'd64 - {1'b0, hdr_bytes_c[5:0]});

  assign sum_c      = SW'(used) + (rb_update_valid ? SW'(rb_update_size) : SW'(0));
  assign sat_c      = (sum_c > SW'(RB_DEPTH)) ? SW'(RB_DEPTH) : sum_c;
  assign used_nxt_c = UW'(sat_c - SW'(issue_c));

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and read-issue decode
  always_comb begin
    state_nxt  = state;
    issue_c    = 1'b0;
    load_hdr_c = 1'b0;
    drop_inc_c = 1'b0;
    tag_c      = '0;
    case (state)
      IDLE: begin
        if (can_issue_c) begin
          issue_c   = 1'b1;
          tag_c     = {1'b1, 9'd0};
          state_nxt = HDR_RD;
        end
      end
      HDR_RD: begin
        if (hdr_ret_c) begin
          load_hdr_c = 1'b1;
          if (hdr_bytes_c == 32'd0) begin
            drop_inc_c = 1'b1;
            state_nxt  = IDLE;
          end else if (hdr_bytes_c > MAX_PDU_BYTES) begin
            state_nxt = DROP;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD, DROP: begin
        if (can_issue_c) begin
          issue_c = 1'b1;
          tag_c   = {1'b0, (state == PAYLOAD), first, last_c, last_c ? last_empty : 6'd0};
          if (last_c) begin
            state_nxt  = IDLE;
            drop_inc_c = (state == DROP);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Occupancy, read pointer, PDU bookkeeping and read-return tracking
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      used            <= '0;
      ovf_err         <= 1'b0;
      rb_almost_full  <= 1'b0;
      rb_rd_en        <= 1'b0;
      rb_rd_addr      <= '0;
      rb_rd_base_addr <= '0;
      rem             <= '0;
      first           <= 1'b0;
      last_empty      <= '0;
      drop_cnt        <= '0;
      inflight        <= '0;
      pv              <= '0;
    end else begin
      used           <= used_nxt_c;
      ovf_err        <= ovf_err || (sum_c > SW'(RB_DEPTH));
      rb_almost_full <= (used_nxt_c >= UW'(RB_DEPTH - AF_MARGIN));
      rb_rd_en       <= issue_c;
      if (issue_c) begin
        rb_rd_addr      <= rb_rd_base_addr;
        rb_rd_base_addr <= rb_rd_base_addr + PDU_AWIDTH'(1);
      end
      if (load_hdr_c) begin
        rem        <= hdr_rem_c;
        first      <= 1'b1;
        last_empty <= hdr_empty_c;
      end else if (issue_c && state != IDLE) begin
        rem   <= rem - REM_W'(1);
        first <= 1'b0;
      end
      if (drop_inc_c) drop_cnt <= drop_cnt + 32'd1;
      inflight <= inflight + FC_W'(issue_c) - FC_W'(pv[RD_LAT]);
      pv       <= {pv[RD_LAT-1:0], issue_c};
    end
  end

  always_ff @(posedge Clk) begin
    pt[0] <= tag_c;
    for (int k = 1; k <= RD_LAT; k++) pt[k] <= pt[k-1];
  end

  always_ff @(posedge Clk) begin
    if (push_c) fifo_mem[wr_idx] <= {pt[RD_LAT][7:0], rb_rd_data};
  end

  // Skid FIFO pointers plus the registered output stage
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      fifo_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
      pdu_cnt   <= '0;
    end else begin
      if (push_c) wr_idx <= (wr_idx == FA_W'(FIFO_DEPTH - 1)) ? '0 : wr_idx + FA_W'(1);
      if (load_out_c) rd_idx <= (rd_idx == FA_W'(FIFO_DEPTH - 1)) ? '0 : rd_idx + FA_W'(1);
      fifo_cnt <= fifo_cnt + FC_W'(push_c) - FC_W'(load_out_c);
      if (load_out_c) begin
        out_valid                                <= 1'b1;
        {out_sop, out_eop, out_empty, out_data}  <= fifo_mem[rd_idx];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && out_eop) pdu_cnt <= pdu_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pdu_rb_reader.sv
// Bench for pdu_rb_reader: ring-RAM model, writer model and scoreboard of expected packets.
module tb_pdu_rb_reader;

  localparam int unsigned AW     = 12;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned AF     = 64;
  localparam int unsigned MAXB   = 9216;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic           rb_update_valid;
  logic [AW-1:0]  rb_update_size;
  logic           rb_rd_en;
  logic [AW-1:0]  rb_rd_addr;
  logic [511:0]   rb_rd_data;
  logic [AW-1:0]  rb_rd_base_addr;
  logic           rb_almost_full;
  logic           enable;
  logic [511:0]   out_data;
  logic           out_sop, out_eop;
  logic [5:0]     out_empty;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    pdu_cnt, drop_cnt;
  logic           ovf_err;

  always #5 Clk = ~Clk;

  pdu_rb_reader #(
    .PDU_AWIDTH(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(8), .AF_MARGIN(AF), .MAX_PDU_BYTES(MAXB)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .rb_update_valid(rb_update_valid), .rb_update_size(rb_update_size),
    .rb_rd_en(rb_rd_en), .rb_rd_addr(rb_rd_addr), .rb_rd_data(rb_rd_data),
    .rb_rd_base_addr(rb_rd_base_addr), .rb_almost_full(rb_almost_full),
    .enable(enable),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_valid(out_valid), .out_ready(out_ready),
    .pdu_cnt(pdu_cnt), .drop_cnt(drop_cnt), .ovf_err(ovf_err)
  );

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

  typedef struct {
    string        name;
    logic [511:0] act;
    logic [511:0] exp;
  } dchk_t;

  flit_t        sb[$];
  dchk_t        chk_q[$];
  int           checks = 0;
  int           errors = 0;
  int           exp_pdu, exp_drop, exp_reads, rd_count;
  logic [AW-1:0] wr, exp_addr;
  logic         rdy_rand, en_rand, en_fix;
  logic         hold_pend;
  flit_t        prev;

  // Ring RAM with a fixed RD_LAT read pipeline
  logic [511:0] ram [DEPTH];
  logic [511:0] rd_pipe [RD_LAT];
  assign rb_rd_data = rd_pipe[RD_LAT-1];

  always @(posedge Clk) begin
    for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    if (rb_rd_en) rd_pipe[0] <= ram[rb_rd_addr];
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic post(input string name, input logic [511:0] act, input logic [511:0] exp);
    dchk_t d;
    d.name = name;
    d.act  = act;
    d.exp  = exp;
    chk_q.push_back(d);
  endtask

  // Monitor: read-address order, hold stability and in-order packet contents
  always @(negedge Clk) begin
    flit_t e;
    while (chk_q.size() != 0) begin
      dchk_t d;
      d = chk_q.pop_front();
      chk(d.name, d.act, d.exp);
    end
    if (!Rst_n) begin
      exp_addr  = '0;
      rd_count  = 0;
      hold_pend = 1'b0;
    end else begin
      if (rb_rd_en) begin
        chk("rd_addr", 512'(rb_rd_addr), 512'(exp_addr));
        exp_addr = exp_addr + AW'(1);
        rd_count++;
      end
      if (hold_pend) begin
        chk("hold_ctl", 512'({out_valid, out_sop, out_eop, out_empty}),
            512'({1'b1, prev.sop, prev.eop, prev.empty}));
        chk("hold_data", out_data, prev.data);
      end
      if (out_valid && out_ready) begin
        chk("flit_expected", 512'(sb.size() != 0), 512'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("flit_ctl", 512'({out_sop, out_eop, out_empty}), 512'({e.sop, e.eop, e.empty}));
          chk("flit_data", out_data, e.data);
        end
      end
      hold_pend = out_valid && !out_ready;
      prev      = {out_data, out_sop, out_eop, out_empty};
    end
  end

  // Sink backpressure and enable jitter
  initial begin
    out_ready = 1'b1;
    enable    = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      enable    = en_rand ? ($urandom_range(0, 7) != 0) : en_fix;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic commit(input int size);
    rb_update_valid = 1'b1;
    rb_update_size  = AW'(size);
    step();
    rb_update_valid = 1'b0;
    rb_update_size  = '0;
  endtask

  function automatic logic [511:0] rnd_flit();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Writer model: lay the PDU into the ring, predict the packet, commit it
  task automatic put_pdu(input int n);
    logic [511:0] w;
    int           nf;
    logic         kept;
    nf   = (n + 63) / 64;
    kept = (n > 0) && (n <= int'(MAXB));
    w = rnd_flit();
    w[31:0] = 32'(n);
    ram[wr] = w;
    wr = wr + AW'(1);
    for (int i = 0; i < nf; i++) begin
      w = rnd_flit();
      ram[wr] = w;
      wr = wr + AW'(1);
      if (kept)
        sb.push_back({w, (i == 0), (i == nf - 1),
                      ((i == nf - 1) && (n % 64 != 0)) ? 6'(64 - n % 64) : 6'd0});
    end
    if (kept) exp_pdu++;
    else      exp_drop++;
    exp_reads += nf + 1;
    commit(nf + 1);
  endtask

  task automatic wait_drain(input string tag);
    int   c;
    logic done;
    c    = 0;
    done = 1'b0;
    while (!done && c < 30000) begin
      step();
      c++;
      done = (sb.size() == 0) && (pdu_cnt == 32'(exp_pdu)) && (drop_cnt == 32'(exp_drop)) &&
             (rd_count == exp_reads) && !out_valid;
    end
    post({tag, "_drain"}, 512'(done), 512'(1));
    post({tag, "_pdu_cnt"}, 512'(pdu_cnt), 512'(exp_pdu));
    post({tag, "_drop_cnt"}, 512'(drop_cnt), 512'(exp_drop));
    post({tag, "_base_addr"}, 512'(rb_rd_base_addr), 512'(wr));
  endtask

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 19);
    case (r)
      0:       return 0;
      1:       return $urandom_range(MAXB + 1, 10000);
      2:       return int'(MAXB);
      3:       return 64 * $urandom_range(1, 8);
      default: return $urandom_range(1, 700);
    endcase
  endfunction

  initial begin
    int   r0, d, k, fl, n;
    logic any;
    Rst_n = 1'b0; rb_update_valid = 1'b0; rb_update_size = '0;
    rdy_rand = 1'b0; en_rand = 1'b0; en_fix = 1'b1;
    wr = '0; exp_pdu = 0; exp_drop = 0; exp_reads = 0;
    repeat (3) step();
    post("rst_valid", 512'(out_valid), 512'(0));
    post("rst_rd_en", 512'(rb_rd_en), 512'(0));
    post("rst_base", 512'(rb_rd_base_addr), 512'(0));
    post("rst_af_ovf", 512'({rb_almost_full, ovf_err}), 512'(0));
    post("rst_cnts", 512'({pdu_cnt, drop_cnt}), 512'(0));
    Rst_n = 1'b1;
    step();

    put_pdu(100);
    wait_drain("n100");

    put_pdu(0);
    put_pdu(10000);
    put_pdu(64);
    wait_drain("drops");
    post("drops_total", 512'(drop_cnt), 512'(2));

    rdy_rand = 1'b1;
    r0 = rd_count;
    for (int i = 0; i < 10; i++) put_pdu(640);
    wait_drain("b2b");
    post("b2b_reads", 512'(rd_count - r0), 512'(110));

    // Bring the write pointer to RB_DEPTH-2, then a 5-flit PDU straddles the wrap
    rdy_rand = 1'b0;
    d = (int'(DEPTH) - 2 - int'(wr) + int'(DEPTH)) % int'(DEPTH);
    while (d > 0) begin
      k = (d > 100) ? 100 : d;
      put_pdu((k == 1) ? 0 : 64 * (k - 1));
      d -= k;
    end
    wait_drain("pad");
    post("pad_at_edge", 512'(rb_rd_base_addr), 512'(DEPTH - 2));
    put_pdu(256);
    wait_drain("wrap");
    post("wrap_base", 512'(rb_rd_base_addr), 512'(3));

    rdy_rand = 1'b1;
    en_rand  = 1'b1;
    for (int b = 0; b < 6; b++) begin
      fl = 0;
      while (fl < 500) begin
        n = pick_len();
        put_pdu(n);
        fl += (n + 63) / 64 + 1;
      end
      wait_drain("rand");
    end

    // Reset in the middle of a long payload with reads in flight
    rdy_rand = 1'b0;
    en_rand  = 1'b0;
    put_pdu(4000);
    repeat (12) step();
    Rst_n = 1'b0;
    step();
    post("midrst_valid", 512'(out_valid), 512'(0));
    post("midrst_rd_en", 512'(rb_rd_en), 512'(0));
    post("midrst_data", out_data, 512'(0));
    post("midrst_ctl", 512'({out_sop, out_eop, out_empty}), 512'(0));
    post("midrst_base", 512'(rb_rd_base_addr), 512'(0));
    post("midrst_cnts", 512'({pdu_cnt, drop_cnt}), 512'(0));
    sb.delete();
    exp_pdu = 0; exp_drop = 0; exp_reads = 0; wr = '0;
    step();
    Rst_n = 1'b1;
    any = 1'b0;
    repeat (30) begin
      step();
      any = any | out_valid | rb_rd_en;
    end
    post("midrst_quiet", 512'(any), 512'(0));

    // Occupancy flags with reads held off
    en_fix = 1'b0;
    step();
    step();
    commit(DEPTH - AF - 1);
    repeat (3) step();
    post("af_below", 512'(rb_almost_full), 512'(0));
    post("ovf_clear", 512'(ovf_err), 512'(0));
    commit(1);
    repeat (3) step();
    post("af_at", 512'(rb_almost_full), 512'(1));
    commit(AF + 1);
    repeat (3) step();
    post("ovf_set", 512'(ovf_err), 512'(1));
    post("af_full", 512'(rb_almost_full), 512'(1));
    post("ovf_no_read", 512'(rb_rd_en), 512'(0));

    repeat (3) @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
